maze_mask_engine: RTL
=====================

Name: maze_mask_engine

Overview:
- Parametrised Q-table masking engine for the grid-maze Q-learning datapath.
- Holds a ROWS x COLS blocked-cell bitmap plus start and target states, loaded through a config port.
- On a start pulse it sweeps every (state, action) pair and issues zero-writes to the external Q memory for every illegal move: leaving the grid, or entering a blocked cell.
- Provides a 1-cycle-latency legal-action query port that the agent's action selector uses every step.

Parameters:
- ROWS, 6, grid rows (>=2).
- COLS, 6, grid columns (>=2).
- QW, 32, Q-value width.
- ZERO_BLOCKED, 0, if 1 also zero all 4 actions of blocked states.
- Localparams: N = ROWS*COLS; SW = $clog2(N).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- cfg_we  in  1  config write strobe
- cfg_sel  in  2  0 = blocked bit, 1 = start_state, 2 = target_state, 3 = clear bitmap
- cfg_state  in  SW  cell index / state value
- cfg_bit  in  1  blocked value (cfg_sel = 0)
- cfg_err  out  1  sticky config error
- start  in  1  begin sweep (pulse)
- busy  out  1  sweep in progress
- done  out  1  sweep complete, held until next accepted start
- q_we  out  1  Q zero-write request
- q_wstate  out  SW  write row (state)
- q_waction  out  2  write column (0 = N, 1 = E, 2 = S, 3 = W)
- q_wdata  out  QW  always 0
- q_wready  in  1  memory accepts write
- start_state  out  SW  configured start
- target_state  out  SW  configured target
- qry_valid  in  1  legal-mask query
- qry_state  in  SW  queried state
- legal_valid  out  1  query result valid
- legal_mask  out  4  bit a = 1 if action a is legal

Behaviour:
- Indexing is zero-based: s = r*COLS + c, row 0 is the south edge.
  - N -> r+1, E -> c+1, S -> r-1, W -> c-1.
  - Action a from s is illegal if the destination is outside the grid or blocked[dest] = 1.
  - If ZERO_BLOCKED = 1, all actions from a blocked s are also illegal.
- Reset (async, any time including mid-sweep):
  - bitmap = 0, start_state = 0, target_state = N-1.
  - busy = done = q_we = cfg_err = legal_valid = 0, legal_mask = 0, FSM -> IDLE.
- Config writes take effect at the edge where cfg_we = 1, and only when busy = 0.
  - A write while busy is ignored and sets cfg_err.
  - Setting blocked = 1 on the current start or target state is ignored and sets cfg_err.
  - cfg_state >= N is ignored and sets cfg_err.
  - cfg_err clears only on rst.
- FSM IDLE/DONE -> SWEEP on start:
  - Counters s = 0, a = 0; busy = 1, done = 0 from the next cycle.
  - start while busy is ignored.
- SWEEP, per pair (s, a):
  - Legal pair: no write; advance next cycle.
  - Illegal pair: q_we = 1 with q_wstate = s, q_waction = a.
  - While q_we = 1 and q_wready = 0, q_we and the address hold stable; advance on the edge where q_we && q_wready.
- Order: a increments 0..3, then s increments; after (N-1, 3) completes -> DONE.
  - DONE: busy = 0, done = 1, q_we = 0.
  - With q_wready held at 1, a sweep takes exactly 4*N cycles from first SWEEP cycle to done.
- Query port:
  - legal_valid = qry_valid registered.
  - legal_mask is computed from the bitmap at the edge the query is sampled.
  - Valid during a sweep.
  - qry_state >= N returns mask 0.

Test Plan:
- 6x6, empty bitmap, q_wready = 1, start:
  - 24 writes: S of states 0-5, N of 30-35, W of 0,6,...,30, E of 5,11,...,35.
  - done asserts 144 cycles after sweep entry.
- Block cell 7, start:
  - 28 writes: the 24 boundary writes plus (1,N), (13,S), (6,E), (8,W).
  - No write for row 7.
  - With ZERO_BLOCKED = 1: 32 writes, including (7,0..3).
- Backpressure: hold q_wready = 0 for 3 cycles on the first write (0,S).
  - q_we, q_wstate = 0 and q_waction = 2 stay stable.
  - Sweep length grows by 3 cycles.
- Queries on the empty bitmap:
  - qry_state = 0 -> next cycle legal_mask = 4'b0011.
  - qry_state = 35 -> 4'b1100.
  - With cell 1 blocked, qry 0 -> 4'b0001.
- Config error cases:
  - cfg write during busy -> bitmap unchanged, cfg_err = 1.
  - Blocking target 35 -> ignored, cfg_err = 1.
- Assert rst mid-sweep:
  - busy, q_we and done drop immediately.
  - bitmap clears; target_state = 35.
  - A new start performs a full 24-write sweep.

Source files
------------

// File: rtl/maze_mask_engine.sv
// Q-table masking engine for the grid maze: holds the blocked-cell bitmap, sweeps all
// (state, action) pairs issuing zero-writes for illegal moves, and answers legal-mask queries.
module maze_mask_engine #(
  parameter  int ROWS         = 6,
  parameter  int COLS         = 6,
  parameter  int QW           = 32,
  parameter  int ZERO_BLOCKED = 0,
  localparam int N            = ROWS * COLS,
  localparam int SW           = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cfg_we,
  input  logic [1:0]    cfg_sel,
  input  logic [SW-1:0] cfg_state,
  input  logic          cfg_bit,
  output logic          cfg_err,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          q_we,
  output logic [SW-1:0] q_wstate,
  output logic [1:0]    q_waction,
  output logic [QW-1:0] q_wdata,
  input  logic          q_wready,
  output logic [SW-1:0] start_state,
  output logic [SW-1:0] target_state,
  input  logic          qry_valid,
  input  logic [SW-1:0] qry_state,
  output logic          legal_valid,
  output logic [3:0]    legal_mask
);

  localparam int          NT    = 1 << SW;
  localparam logic [SW:0] N_EXT = (SW + 1)'(N);

  typedef enum logic [1:0] {ST_IDLE, ST_SWEEP, ST_DONE} state_e;

  state_e          state_q, state_d;
  logic [SW-1:0]   s_q, s_d;
  logic [1:0]      a_q, a_d;
  logic [N-1:0]    bitmap_q, bitmap_d;
  logic [SW-1:0]   start_state_q, start_state_d;
  logic [SW-1:0]   target_state_q, target_state_d;
  logic            cfg_err_q, cfg_err_d;
  logic            legal_valid_q, legal_valid_d;
  logic [3:0]      legal_mask_q, legal_mask_d;

  // Per-state legal-action table, shared by the sweep and the query port.
  // Indices past N-1 read as "no legal action".
  logic [3:0] legal_tab [NT];

  for (genvar gs = 0; gs < NT; gs++) begin : g_cell
    if (gs < N) begin : g_in
      localparam int R = gs / COLS;
      localparam int C = gs % COLS;
      logic [3:0] reach;
      if (R < ROWS - 1) begin : g_n
        assign reach[0] = ~bitmap_q[gs + COLS];
      end else begin : g_n_edge
        assign reach[0] = 1'b0;
      end
      if (C < COLS - 1) begin : g_e
        assign reach[1] = ~bitmap_q[gs + 1];
      end else begin : g_e_edge
        assign reach[1] = 1'b0;
      end
      if (R > 0) begin : g_s
        assign reach[2] = ~bitmap_q[gs - COLS];
      end else begin : g_s_edge
        assign reach[2] = 1'b0;
      end
      if (C > 0) begin : g_w
        assign reach[3] = ~bitmap_q[gs - 1];
      end else begin : g_w_edge
        assign reach[3] = 1'b0;
      end
      assign legal_tab[gs] = ((ZERO_BLOCKED != 0) && bitmap_q[gs]) ? 4'b0000 : reach;
    end else begin : g_out
      assign legal_tab[gs] = 4'b0000;
    end
  end

  logic sweeping, pair_illegal, advance, last_pair;
  logic cfg_in_range, cfg_hits_ends, cfg_reject;

  assign sweeping     = (state_q == ST_SWEEP);
  assign pair_illegal = ~legal_tab[s_q][a_q];
  // A legal pair needs no write, so it never waits on the memory.
  assign advance      = sweeping && (!pair_illegal || q_wready);
  assign last_pair    = (s_q == SW'(N - 1)) && (a_q == 2'd3);

  assign cfg_in_range  = {1'b0, cfg_state} < N_EXT;
  assign cfg_hits_ends = (cfg_state == start_state_q) || (cfg_state == target_state_q);
  assign cfg_reject    = sweeping || !cfg_in_range ||
                         ((cfg_sel == 2'd0) && cfg_bit && cfg_hits_ends);

  // FSM next state
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    state_d = state_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: if (start) state_d = ST_SWEEP;
      ST_SWEEP:         if (advance && last_pair) state_d = ST_DONE;
      default:          state_d = ST_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy      = sweeping;
    done      = (state_q == ST_DONE);
    q_we      = sweeping && pair_illegal;
    q_wstate  = s_q;
    q_waction = a_q;
    q_wdata   = '0;
  end

  // Sweep counters, configuration registers and query pipeline
  always_comb begin
    s_d            = s_q;
    a_d            = a_q;
    bitmap_d       = bitmap_q;
    start_state_d  = start_state_q;
    target_state_d = target_state_q;
    cfg_err_d      = cfg_err_q;
    legal_valid_d  = qry_valid;
    legal_mask_d   = legal_mask_q;

    if (!sweeping && start) begin
      s_d = '0;
      a_d = '0;
    end else if (advance) begin
      a_d = a_q + 2'd1;
      if (a_q == 2'd3) s_d = s_q + SW'(1);
    end

    if (cfg_we) begin
      if (cfg_reject) begin
        cfg_err_d = 1'b1;
      end else begin
        unique case (cfg_sel)
          2'd0:    bitmap_d[cfg_state] = cfg_bit;
          2'd1:    start_state_d       = cfg_state;
          2'd2:    target_state_d      = cfg_state;
          default: bitmap_d            = '0;
        endcase
      end
    end

    if (qry_valid) legal_mask_d = legal_tab[qry_state];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the bitmap is a plain register bank, reset on purpose so a reset always yields an open maze.
      state_q        <= ST_IDLE;
      s_q            <= '0;
      a_q            <= '0;
      bitmap_q       <= '0;
      start_state_q  <= '0;
      target_state_q <= SW'(N - 1);
      cfg_err_q      <= 1'b0;
      legal_valid_q  <= 1'b0;
      legal_mask_q   <= 4'b0000;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q        <= state_d;
      s_q            <= s_d;
      a_q            <= a_d;
      bitmap_q       <= bitmap_d;
      start_state_q  <= start_state_d;
      target_state_q <= target_state_d;
      cfg_err_q      <= cfg_err_d;
      legal_valid_q  <= legal_valid_d;
      legal_mask_q   <= legal_mask_d;
    end
  end

  assign cfg_err      = cfg_err_q;
  assign start_state  = start_state_q;
  assign target_state = target_state_q;
  assign legal_valid  = legal_valid_q;
  assign legal_mask   = legal_mask_q;

endmodule
